// File: rtl/heap_pkg.sv
// Shared heap geometry and the move sequencer state type.
// The geometry values are used by the controller, its address generator and the bench.
package heap_pkg;

  localparam int MemoryElementWidth = 12;
  localparam int NArea              = 9;
  localparam int NArrays            = 2;
  localparam int NHeap              = NArea * NArrays;
  localparam int HeapAddrW          = $clog2(NHeap);
  localparam int MEW                = MemoryElementWidth;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COPY,
    ST_DRAIN,
    ST_SIZE,
    ST_DONE
  } move_state_t;

  // Zero-extended sum so that offset+length bounds checks cannot wrap.
  function automatic logic [MEW:0] ext_sum(input logic [MEW-1:0] a, input logic [MEW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/heap_addr_gen.sv
// Maps (array, offset, index) to a flat heap word address.
// Callers only present operands that have already passed the bounds check.
module heap_addr_gen
  import heap_pkg::*;
(
  input  logic [MEW-1:0]       array_i,
  input  logic [MEW-1:0]       offset_i,
  input  logic [MEW-1:0]       index_i,
  output logic [HeapAddrW-1:0] addr_o
);

  localparam logic [MEW-1:0] AREA = MEW'(NArea);

  assign addr_o = HeapAddrW'(array_i * AREA + offset_i + index_i);

endmodule

// File: rtl/move_long_controller.sv
// Sequences one moveLong block copy through a 1R/1W heap RAM, one element per cycle,
// then raises the target array length when the copy extends past it.
module move_long_controller
  import heap_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic [MEW-1:0]       src_array_i,
  input  logic [MEW-1:0]       src_offset_i,
  input  logic [MEW-1:0]       tgt_array_i,
  input  logic [MEW-1:0]       tgt_offset_i,
  input  logic [MEW-1:0]       length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 mem_rd_en_o,
  output logic [HeapAddrW-1:0] mem_rd_addr_o,
  input  logic [MEW-1:0]       mem_rd_data_i,
  output logic                 mem_wr_en_o,
  output logic [HeapAddrW-1:0] mem_wr_addr_o,
  output logic [MEW-1:0]       mem_wr_data_o,
  input  logic [MEW-1:0]       size_rd_data_i,
  output logic                 size_wr_en_o,
  output logic [MEW-1:0]       size_wr_array_o,
  output logic [MEW-1:0]       size_wr_value_o
);

  localparam logic [MEW:0]   AREA_LIMIT  = (MEW+1)'(NArea);
  localparam logic [MEW-1:0] ARRAY_LIMIT = MEW'(NArrays);
  localparam logic [MEW-1:0] ONE         = MEW'(1);

  move_state_t          state_q;
  logic [MEW-1:0]       src_arr_q, src_off_q, tgt_arr_q, tgt_off_q, len_q;
  logic [MEW-1:0]       rd_idx_q, wr_idx_q, cnt_q;
  logic                 busy_q, done_q, error_q;
  logic                 rd_en_q, wr_en_q, size_en_q;
  logic [MEW-1:0]       size_arr_q, size_val_q;

  logic [MEW:0]         src_end, tgt_end;
  logic                 bad_cmd, descending;
  logic [HeapAddrW-1:0] rd_addr, wr_addr;

  assign src_end = ext_sum(src_off_q, len_q);
  assign tgt_end = ext_sum(tgt_off_q, len_q);
  assign bad_cmd = (src_arr_q >= ARRAY_LIMIT) || (tgt_arr_q >= ARRAY_LIMIT) ||
                   (src_end > AREA_LIMIT) || (tgt_end > AREA_LIMIT);
  // Copy high-to-low when the target overlaps above the source so no source word is clobbered early.
  assign descending = (src_arr_q == tgt_arr_q) && (tgt_off_q > src_off_q);

  heap_addr_gen u_rd_addr (
    .array_i  (src_arr_q),
    .offset_i (src_off_q),
    .index_i  (rd_idx_q),
    .addr_o   (rd_addr)
  );

  heap_addr_gen u_wr_addr (
    .array_i  (tgt_arr_q),
    .offset_i (tgt_off_q),
    .index_i  (wr_idx_q),
    .addr_o   (wr_addr)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      src_arr_q  <= '0;
      src_off_q  <= '0;
      tgt_arr_q  <= '0;
      tgt_off_q  <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      size_en_q  <= 1'b0;
      size_arr_q <= '0;
      size_val_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_arr_q <= src_array_i;
            src_off_q <= src_offset_i;
            tgt_arr_q <= tgt_array_i;
            tgt_off_q <= tgt_offset_i;
            len_q     <= length_i;
            busy_q    <= 1'b1;
            state_q   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bad_cmd) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (len_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            rd_idx_q <= descending ? (len_q - ONE) : '0;
            cnt_q    <= ONE;
            rd_en_q  <= 1'b1;
            state_q  <= ST_COPY;
          end
        end
        ST_COPY: begin
          // The word read this cycle is written next cycle, when its data arrives.
          wr_en_q  <= 1'b1;
          wr_idx_q <= rd_idx_q;
          if (cnt_q == len_q) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            rd_idx_q <= descending ? (rd_idx_q - ONE) : (rd_idx_q + ONE);
            cnt_q    <= cnt_q + ONE;
          end
        end
        ST_DRAIN: begin
          wr_en_q    <= 1'b0;
          size_en_q  <= tgt_end > {1'b0, size_rd_data_i};
          size_arr_q <= tgt_arr_q;
          size_val_q <= tgt_end[MEW-1:0];
          state_q    <= ST_SIZE;
        end
        ST_SIZE: begin
          size_en_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign mem_rd_en_o     = rd_en_q;
  assign mem_rd_addr_o   = rd_en_q ? rd_addr : '0;
  assign mem_wr_en_o     = wr_en_q;
  assign mem_wr_addr_o   = wr_en_q ? wr_addr : '0;
  assign mem_wr_data_o   = wr_en_q ? mem_rd_data_i : '0;
  assign size_wr_en_o    = size_en_q;
  assign size_wr_array_o = size_arr_q;
  assign size_wr_value_o = size_val_q;

endmodule

// File: tb/tb_move_long_controller.sv
// Scoreboard bench for move_long_controller: a buffered-copy reference model queues the
// expected writes, size updates and completions; a negedge monitor pops and compares them.
module tb_move_long_controller;
  import heap_pkg::*;

  localparam int AW = HeapAddrW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [MEW-1:0]  src_arr = '0, src_off = '0, tgt_arr = '0, tgt_off = '0, len = '0;
  logic            busy, done, error;
  logic            rd_en, wr_en, size_wr_en;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [MEW-1:0]  rd_data = '0;
  logic [MEW-1:0]  wr_data, size_rd, size_wr_arr, size_wr_val;

  logic [MEW-1:0]  mem [NHeap];
  logic [MEW-1:0]  sizes [NArrays];
  int              ref_heap [NHeap];
  int              ref_sizes [NArrays];
  int              cur_tgt = 0;
  int              cyc = 0;
  int              start_cyc = 0;
  int              done_cnt = 0;
  int              checks = 0;
  int              errors = 0;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int arr; int val; } sz_t;
  typedef struct { int err; int lat; } dn_t;
  wr_t exp_wr_q[$];
  sz_t exp_sz_q[$];
  dn_t exp_dn_q[$];
  wr_t mw;
  sz_t ms;
  dn_t md;

  move_long_controller dut (
    .clock_i         (clk),
    .reset_ni        (rst_n),
    .start_i         (start),
    .src_array_i     (src_arr),
    .src_offset_i    (src_off),
    .tgt_array_i     (tgt_arr),
    .tgt_offset_i    (tgt_off),
    .length_i        (len),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (error),
    .mem_rd_en_o     (rd_en),
    .mem_rd_addr_o   (rd_addr),
    .mem_rd_data_i   (rd_data),
    .mem_wr_en_o     (wr_en),
    .mem_wr_addr_o   (wr_addr),
    .mem_wr_data_o   (wr_data),
    .size_rd_data_i  (size_rd),
    .size_wr_en_o    (size_wr_en),
    .size_wr_array_o (size_wr_arr),
    .size_wr_value_o (size_wr_val)
  );

  always #5 clk = ~clk;

  assign size_rd = (cur_tgt < NArrays) ? sizes[cur_tgt] : '0;

  // Heap RAM with one-cycle registered read, plus the arraySizes store.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && int'(rd_addr) < NHeap) rd_data <= mem[rd_addr];
    if (wr_en && int'(wr_addr) < NHeap) mem[wr_addr] <= wr_data;
    if (size_wr_en && int'(size_wr_arr) < NArrays) sizes[int'(size_wr_arr)] <= size_wr_val;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr_q.size() == 0) fail_now("unexpected_mem_write");
        else begin
          mw = exp_wr_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(mw.addr));
          chk("wr_data", 64'(wr_data), 64'(mw.data));
        end
      end
      if (size_wr_en) begin
        if (exp_sz_q.size() == 0) fail_now("unexpected_size_write");
        else begin
          ms = exp_sz_q.pop_front();
          chk("size_array", 64'(size_wr_arr), 64'(ms.arr));
          chk("size_value", 64'(size_wr_val), 64'(ms.val));
        end
      end
      if (done) begin
        if (exp_dn_q.size() == 0) fail_now("unexpected_done");
        else begin
          md = exp_dn_q.pop_front();
          chk("done_latency", 64'(cyc - start_cyc), 64'(md.lat));
          chk("error_flag", 64'(error), 64'(md.err));
          chk("writes_outstanding", 64'(exp_wr_q.size()), 0);
          chk("size_outstanding", 64'(exp_sz_q.size()), 0);
        end
        done_cnt++;
      end
    end
  end

  task automatic init_heap(input bit rnd, input int s0, input int s1);
    int v;
    for (int i = 0; i < NHeap; i++) begin
      v = rnd ? int'($urandom_range(0, 4095)) : ((i < NArea) ? i : 100 + i - NArea);
      mem[i] <= MEW'(v);
      ref_heap[i] = v;
    end
    sizes[0] <= MEW'(s0);
    sizes[1] <= MEW'(s1);
    ref_sizes[0] = s0;
    ref_sizes[1] = s1;
  endtask

  // Reference: buffer the whole source block, then write it in the safe order.
  task automatic issue(input int sa, input int so, input int ta, input int to, input int ln,
                       input bit extra);
    int  buffer [NArea];
    int  i;
    bit  err, desc;
    dn_t d;
    err = (sa >= NArrays) || (ta >= NArrays) || (so + ln > NArea) || (to + ln > NArea);
    if (!err && ln > 0) begin
      for (int k = 0; k < ln; k++) buffer[k] = ref_heap[sa * NArea + so + k];
      desc = (sa == ta) && (to > so);
      for (int k = 0; k < ln; k++) begin
        i = desc ? ln - 1 - k : k;
        exp_wr_q.push_back('{ta * NArea + to + i, buffer[i]});
        ref_heap[ta * NArea + to + i] = buffer[i];
      end
      if (to + ln > ref_sizes[ta]) begin
        exp_sz_q.push_back('{ta, to + ln});
        ref_sizes[ta] = to + ln;
      end
    end
    d.err = err ? 1 : 0;
    d.lat = (err || ln == 0) ? 2 : ln + 4;
    exp_dn_q.push_back(d);
    @(posedge clk); #1;
    src_arr = MEW'(sa); src_off = MEW'(so); tgt_arr = MEW'(ta); tgt_off = MEW'(to); len = MEW'(ln);
    cur_tgt = ta;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra) begin
      @(posedge clk); #1;
      chk("busy_during_cmd", 64'(busy), 1);
      src_arr = 1; src_off = 0; tgt_arr = 0; tgt_off = 0; len = 9;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n0 = done_cnt;
    for (int k = 0; k < 60 && done_cnt == n0; k++) @(posedge clk);
    if (done_cnt == n0) fail_now("done_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_done", 64'(busy), 0);
    for (int k = 0; k < NHeap; k++) chk("heap_word", 64'(mem[k]), 64'(ref_heap[k]));
    for (int k = 0; k < NArrays; k++) chk("array_size", 64'(sizes[k]), 64'(ref_sizes[k]));
  endtask

  task automatic check_area(input int base, input int exp_vals [NArea]);
    for (int k = 0; k < NArea; k++) chk("area_word", 64'(mem[base + k]), 64'(exp_vals[k]));
  endtask

  int exp_ov [NArea];
  int sa, ta, so, to, ln;

  initial begin
    init_heap(0, 9, 9);
    #2;
    chk("reset_outputs", {busy, done, error, rd_en, rd_addr, wr_en, wr_addr, wr_data,
                          size_wr_en, size_wr_arr, size_wr_val}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain move a0[4] -> a1[2], len 3.
    issue(0, 4, 1, 2, 3, 0);
    wait_done();
    chk("a1_2", 64'(mem[11]), 4);
    chk("a1_3", 64'(mem[12]), 5);
    chk("a1_4", 64'(mem[13]), 6);

    // Move that extends target length.
    init_heap(0, 9, 2);
    issue(0, 0, 1, 5, 4, 0);
    wait_done();
    chk("a1_new_size", 64'(sizes[1]), 9);

    // Overlapping moves in both directions.
    init_heap(0, 9, 9);
    issue(0, 0, 0, 2, 5, 0);
    wait_done();
    exp_ov = '{0, 1, 0, 1, 2, 3, 4, 7, 8};
    check_area(0, exp_ov);
    init_heap(0, 9, 9);
    issue(0, 2, 0, 0, 5, 0);
    wait_done();
    exp_ov = '{2, 3, 4, 5, 6, 5, 6, 7, 8};
    check_area(0, exp_ov);

    // Rejected commands, zero length, start while busy.
    issue(0, 0, 1, 7, 3, 0);
    wait_done();
    issue(2, 0, 0, 0, 1, 0);
    wait_done();
    issue(0, 3, 1, 3, 0, 0);
    wait_done();
    issue(0, 1, 1, 1, 5, 1);
    wait_done();

    // Reset in the middle of a long copy.
    init_heap(0, 9, 9);
    issue(0, 0, 1, 0, 9, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_mid_copy", {busy, done, error, rd_en, rd_addr, wr_en, wr_addr, wr_data,
                           size_wr_en, size_wr_arr, size_wr_val}, 0);
    exp_wr_q.delete();
    exp_sz_q.delete();
    exp_dn_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    init_heap(0, 9, 3);
    issue(1, 0, 0, 4, 5, 0);
    wait_done();

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) init_heap(1, $urandom_range(0, 9), $urandom_range(0, 9));
      sa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      ta = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      so = $urandom_range(0, 8);
      to = $urandom_range(0, 8);
      ln = $urandom_range(0, 9);
      issue(sa, so, ta, to, ln, 0);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
